// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard
//   ID-stage hazard and forwarding controller. A shift-register scoreboard
//   tracks the last DEPTH issued instructions (stage 1 = EXE .. DEPTH = WB),
//   each with its destination and the stage at which its result becomes
//   forwardable. Per ID source operand it produces a forwarding-stage select,
//   and it raises a global stall on an unready producer or on a busy,
//   non-pipelined multiply/divide unit (MDU).
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   id_valid       ID holds a real instruction
//   id_src/id_use  NSRC source register numbers and their read enables
//   id_wreg        ID instruction writes id_dest
//   id_dest        destination register
//   id_class       00 ALU, 01 load, 10 MDU, 11 ALU
//   stall/wpcir    hold PC and IF/ID (wpcir = ~stall)
//   issue          instruction leaves ID this cycle
//   fwd            per-operand select: 0 = register file, k = stage k
//   mdu_busy       MDU cannot accept a new op
//   stall_count    saturating number of stall cycles
module pipe_hazard_scoreboard #(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 3,
  parameter int MDU_II   = 4,
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [NSRC*AW-1:0] id_src,
  input  logic [NSRC-1:0]    id_use,
  input  logic               id_wreg,
  input  logic [AW-1:0]      id_dest,
  input  logic [1:0]         id_class,
  output logic               stall,
  output logic               wpcir,
  output logic               issue,
  output logic [NSRC*SW-1:0] fwd,
  output logic               mdu_busy,
  output logic [31:0]        stall_count
);

  // Wide enough to hold MDU_II-1.
  localparam int MCW = (MDU_II > 1) ? $clog2(MDU_II) : 1;

  // Scoreboard: index s holds the instruction at pipeline stage s+1.
  logic [DEPTH-1:0] valid_reg;
  logic [AW-1:0]    dest_reg [DEPTH];
  logic [SW-1:0]    age_reg  [DEPTH];

  logic [MCW-1:0]   mc_reg;
  logic [31:0]      stall_count_reg;

  logic [NSRC-1:0]  hazard;
  logic [SW-1:0]    new_age;
  logic             new_entry;
  logic             mdu_op;

  // Stage at which the ID instruction's result becomes forwardable.
  always_comb begin
    new_age = SW'(1);
    case (id_class)
      2'b01:   new_age = SW'(1 + LOAD_LAT);
      2'b10:   new_age = SW'(MDU_LAT);
      default: new_age = SW'(1);
    endcase
  end

  // Per-operand youngest-match search. Scanning from oldest to youngest
  // lets the youngest match overwrite older ones; an older ready match is
  // deliberately ignored when a younger one is still pending.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      logic [AW-1:0] src;
      logic          found;
      logic          ready;
      logic [SW-1:0] stage;
      logic          live;

      assign src  = id_src[gi*AW +: AW];
      assign live = id_valid & id_use[gi] & (src != '0);

      always_comb begin
        found = 1'b0;
        ready = 1'b0;
        stage = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
          if (valid_reg[s] && dest_reg[s] == src) begin
            found = 1'b1;
            stage = SW'(s + 1);
            ready = (SW'(s + 1) >= age_reg[s]);
          end
        end
      end

      assign hazard[gi]           = live & found & ~ready;
      assign fwd[gi*SW +: SW]     = (live & found & ready) ? stage : '0;
    end
  endgenerate

  assign mdu_busy    = (mc_reg != '0);
  assign stall       = id_valid & ((|hazard) | ((id_class == 2'b10) & mdu_busy));
  assign wpcir       = ~stall;
  assign issue       = id_valid & ~stall;
  assign new_entry   = issue & id_wreg & (id_dest != '0);
  assign mdu_op      = issue & (id_class == 2'b10);
  assign stall_count = stall_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg       <= '0;
      mc_reg          <= '0;
      stall_count_reg <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        dest_reg[s] <= '0;
        age_reg[s]  <= '0;
      end
    end else begin
      // Advance the pipeline; the oldest entry simply falls off (retires).
      for (int s = DEPTH - 1; s > 0; s--) begin
        valid_reg[s] <= valid_reg[s-1];
        dest_reg[s]  <= dest_reg[s-1];
        age_reg[s]   <= age_reg[s-1];
      end
      // Non-writing instructions, stalls and empty ID all become bubbles.
      valid_reg[0] <= new_entry;
      dest_reg[0]  <= id_dest;
      age_reg[0]   <= new_age;

      if (mdu_op)
        mc_reg <= MCW'(MDU_II - 1);
      else if (mc_reg != '0)
        mc_reg <= mc_reg - 1'b1;

      if (stall && stall_count_reg != '1)
        stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard (default parameters). Directed scenarios
// check hand-derived constants; a randomized run checks against a model that
// records every issued instruction with its issue cycle and derives stage,
// readiness and MDU occupancy from cycle arithmetic.
module tb_pipe_hazard_scoreboard;
  localparam int AW = 5, NSRC = 2, DEPTH = 3, LOAD_LAT = 1, MDU_LAT = 3, MDU_II = 4;
  localparam int SW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [9:0]  id_src = '0;
  logic [1:0]  id_use = '0;
  logic        id_wreg = 1'b0;
  logic [4:0]  id_dest = '0;
  logic [1:0]  id_class = '0;
  logic        stall, wpcir, issue, mdu_busy;
  logic [3:0]  fwd;
  logic [31:0] stall_count;
  wire  [7:0]  obs = {stall, wpcir, issue, mdu_busy, fwd};

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard #(
    .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
    .MDU_LAT(MDU_LAT), .MDU_II(MDU_II), .SW(SW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_use(id_use),
    .id_wreg(id_wreg), .id_dest(id_dest), .id_class(id_class), .stall(stall),
    .wpcir(wpcir), .issue(issue), .fwd(fwd), .mdu_busy(mdu_busy),
    .stall_count(stall_count)
  );

  // ---------------- reference model ----------------
  typedef struct {int c; logic [4:0] d; int rdy;} ent_t;
  ent_t        hist[$];
  int          cyc = 0;
  int          last_mdu = -1000;
  int          m_stalls = 0;
  logic        m_stall;
  logic [7:0]  exp_obs;

  function automatic void model_clear();
    hist.delete();
    cyc = 0;
    last_mdu = -1000;
    m_stalls = 0;
  endfunction

  function automatic void model_eval();
    logic [3:0] f;
    logic       haz, busy;
    logic [4:0] s;
    int         st;
    f = '0;
    haz = 1'b0;
    busy = ((cyc - last_mdu) >= 1) && ((cyc - last_mdu) <= MDU_II - 1);
    for (int i = 0; i < NSRC; i++) begin
      s = id_src[i*AW +: AW];
      if (id_valid && id_use[i] && s != 0) begin
        for (int k = hist.size() - 1; k >= 0; k--) begin
          st = cyc - hist[k].c;
          if (st <= DEPTH && hist[k].d == s) begin
            if (st >= hist[k].rdy) f[i*SW +: SW] = st[SW-1:0];
            else haz = 1'b1;
            break;
          end
        end
      end
    end
    m_stall = id_valid && (haz || (id_class == 2'b10 && busy));
    exp_obs = {m_stall, ~m_stall, id_valid & ~m_stall, busy, f};
  endfunction

  // Advance one clock: model update mirrors what the spec says happens at the edge.
  task automatic tick();
    int rdy;
    model_eval();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (m_stall) m_stalls++;
      if (id_valid && !m_stall) begin
        rdy = (id_class == 2'b01) ? 1 + LOAD_LAT : (id_class == 2'b10) ? MDU_LAT : 1;
        if (id_wreg && id_dest != 0) hist.push_back('{cyc, id_dest, rdy});
        if (id_class == 2'b10) last_mdu = cyc;
      end
      cyc++;
      while (hist.size() > 0 && cyc - hist[0].c > DEPTH) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] u, input logic w, input logic [4:0] d,
                       input logic [1:0] c);
    id_valid = v; id_src = {s1, s0}; id_use = u; id_wreg = w; id_dest = d; id_class = c;
    #2;
    model_eval();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'b00);
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 2'b00);
    compared++;
    if (obs !== 8'b0110_0000 || stall_count !== 32'd0) begin
      mismatched++;
      $display("FAIL reset obs=%b cnt=%0d want obs=01100000 cnt=0", obs, stall_count);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_alu_chain();
    apply_reset();
    drive(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 2'b00);  // add $3
    compared++;
    if (obs !== 8'b0110_0000) begin mismatched++; $display("FAIL alu_add obs=%b want 01100000", obs); end
    tick();
    drive(1'b1, 5'd3, 5'd3, 2'b11, 1'b1, 5'd4, 2'b00);  // sub $4,$3,$3
    compared++;
    if (obs !== 8'b0110_0101) begin mismatched++; $display("FAIL alu_fwd1 obs=%b want 01100101", obs); end
    tick();
    drive(1'b1, 5'd3, 5'd0, 2'b11, 1'b1, 5'd10, 2'b00);
    compared++;
    if (obs !== 8'b0110_0010) begin mismatched++; $display("FAIL alu_fwd2 obs=%b want 01100010", obs); end
    tick();
    drive(1'b1, 5'd3, 5'd0, 2'b11, 1'b1, 5'd11, 2'b00);
    compared++;
    if (obs !== 8'b0110_0011) begin mismatched++; $display("FAIL alu_fwd3 obs=%b want 01100011", obs); end
    tick();
    drive(1'b1, 5'd3, 5'd0, 2'b11, 1'b1, 5'd12, 2'b00);
    compared++;
    if (obs !== 8'b0110_0000) begin mismatched++; $display("FAIL alu_retired obs=%b want 01100000", obs); end
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b01, 1'b1, 5'd5, 2'b01);  // lw $5
    tick();
    drive(1'b1, 5'd5, 5'd0, 2'b11, 1'b1, 5'd6, 2'b00);  // add $6,$5,$0
    compared++;
    if (obs !== 8'b1000_0000) begin mismatched++; $display("FAIL lu_stall obs=%b want 10000000", obs); end
    tick();
    compared++;
    if (obs !== 8'b0110_0010 || stall_count !== 32'd1) begin
      mismatched++;
      $display("FAIL lu_issue obs=%b cnt=%0d want obs=01100010 cnt=1", obs, stall_count);
    end
    tick();
  endtask

  task automatic test_youngest();
    apply_reset();
    drive(1'b1, 5'd1, 5'd2, 2'b00, 1'b1, 5'd7, 2'b00);  // add $7
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 2'b01);  // lw $7
    tick();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 1'b1, 5'd8, 2'b00);  // or $8,$7
    compared++;
    if (obs !== 8'b1000_0000) begin mismatched++; $display("FAIL young_stall obs=%b want 10000000", obs); end
    tick();
    compared++;
    if (obs !== 8'b0110_0010) begin mismatched++; $display("FAIL young_fwd obs=%b want 01100010", obs); end
    tick();
  endtask

  task automatic test_zero_unused();
    apply_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 2'b01);  // lw $0
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd1, 2'b00);
    compared++;
    if (obs !== 8'b0110_0000) begin mismatched++; $display("FAIL zero_reg obs=%b want 01100000", obs); end
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 2'b01);  // lw $9
    tick();
    drive(1'b1, 5'd9, 5'd9, 2'b00, 1'b0, 5'd0, 2'b00);  // j, no operands read
    compared++;
    if (obs !== 8'b0110_0000 || stall_count !== 32'd0) begin
      mismatched++;
      $display("FAIL unused obs=%b cnt=%0d want obs=01100000 cnt=0", obs, stall_count);
    end
    tick();
  endtask

  task automatic test_mdu();
    apply_reset();
    drive(1'b1, 5'd1, 5'd2, 2'b00, 1'b1, 5'd11, 2'b10);  // mul -> $11
    compared++;
    if (obs !== 8'b0110_0000) begin mismatched++; $display("FAIL mdu_first obs=%b want 01100000", obs); end
    tick();
    drive(1'b1, 5'd1, 5'd2, 2'b00, 1'b1, 5'd12, 2'b10);  // second mul
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (obs !== 8'b1001_0000) begin mismatched++; $display("FAIL mdu_b2b_stall%0d obs=%b want 10010000", i, obs); end
      tick();
    end
    compared++;
    if (obs !== 8'b0110_0000 || stall_count !== 32'd3) begin
      mismatched++;
      $display("FAIL mdu_b2b_issue obs=%b cnt=%0d want obs=01100000 cnt=3", obs, stall_count);
    end
    tick();
    // Consumer of an MDU result three stages behind it forwards from stage 3.
    apply_reset();
    drive(1'b1, 5'd1, 5'd2, 2'b00, 1'b1, 5'd11, 2'b10);
    tick();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'b00);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (obs !== 8'b0101_0000) begin mismatched++; $display("FAIL mdu_busy%0d obs=%b want 01010000", i, obs); end
      tick();
    end
    drive(1'b1, 5'd11, 5'd0, 2'b01, 1'b1, 5'd14, 2'b00);
    compared++;
    if (obs !== 8'b0111_0011) begin mismatched++; $display("FAIL mdu_fwd3 obs=%b want 01110011", obs); end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1'b1, 5'd1, 5'd2, 2'b00, 1'b1, 5'd13, 2'b10);
    tick();
    drive(1'b1, 5'd13, 5'd0, 2'b01, 1'b1, 5'd15, 2'b10);  // stalls on $13 and MDU
    tick();
    compared++;
    if (obs !== 8'b1001_0000 || stall_count !== 32'd1) begin
      mismatched++;
      $display("FAIL mid_prestall obs=%b cnt=%0d want obs=10010000 cnt=1", obs, stall_count);
    end
    rst = 1'b1;  // asynchronous assertion between edges
    #1;
    model_clear();
    compared++;
    if (obs !== 8'b0110_0000 || stall_count !== 32'd0) begin
      mismatched++;
      $display("FAIL mid_reset obs=%b cnt=%0d want obs=01100000 cnt=0", obs, stall_count);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic v, w;
    logic [4:0] s0, s1, d;
    logic [1:0] u, c;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      // A stalled instruction is usually held in ID, as the real pipeline does.
      if (!(m_stall && $urandom_range(0, 9) < 7)) begin
        v  = ($urandom_range(0, 9) < 8);
        s0 = 5'($urandom_range(0, 7));
        s1 = 5'($urandom_range(0, 7));
        u  = 2'($urandom_range(0, 3));
        w  = 1'($urandom_range(0, 1));
        d  = 5'($urandom_range(0, 7));
        c  = 2'($urandom_range(0, 3));
      end
      drive(v, s0, s1, u, w, d, c);
      compared++;
      if (obs !== exp_obs || stall_count !== 32'(m_stalls)) begin
        mismatched++;
        $display("FAIL rand%0d obs=%b cnt=%0d want obs=%b cnt=%0d", n, obs, stall_count, exp_obs, m_stalls);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_zero_unused();
    test_mdu();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_scoreboard.md
# pipe_hazard_scoreboard

Parametrised hazard and forwarding controller for the ID stage of the pipelined MIPS core, replacing the fixed-depth load-use/forwarding logic. It keeps a shift-register scoreboard of the last DEPTH issued instructions, each with its destination and result-availability age. From that it generates, per ID source operand, a forwarding-stage select plus a global stall/wpcir. It also enforces a structural hazard on a non-pipelined multiply/divide unit (MDU).

## Interface
Parameters:
- AW, 5, register address width; register 0 is never tracked.
- NSRC, 2, number of ID source operands checked.
- DEPTH, 3, pipeline stages after ID (stage 1 = EXE … stage DEPTH = WB); must be ≥ max(1+LOAD_LAT, MDU_LAT).
- LOAD_LAT, 1, extra cycles beyond EXE before load data is forwardable (load ready at stage 1+LOAD_LAT).
- MDU_LAT, 3, stage at which an MDU result is forwardable.
- MDU_II, 4, MDU initiation interval in cycles.
- SW, $clog2(DEPTH+1), forwarding select width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NSRC*AW  source register numbers, operand i at bits [i*AW +: AW].
- id_use  in  NSRC  operand i actually read.
- id_wreg  in  1  ID instruction writes a register.
- id_dest  in  AW  destination register.
- id_class  in  2  00 ALU, 01 load, 10 MDU, 11 treated as ALU.
- stall  out  1  hold PC and IF/ID; insert bubble into stage 1.
- wpcir  out  1  ~stall.
- issue  out  1  id_valid & ~stall.
- fwd  out  NSRC*SW  per operand: 0 = register file, k = forward from stage k.
- mdu_busy  out  1  MDU occupied.
- stall_count  out  32  saturating count of stall cycles.

## Operation
- Scoreboard entry e[s], s=1..DEPTH: {valid, dest, rdy_age}. rdy_age = 1 for ALU, 1+LOAD_LAT for load, MDU_LAT for MDU.
- Entry at stage s is "ready" when s ≥ rdy_age.
- Each cycle, e[s+1] ← e[s] for s < DEPTH, and e[DEPTH] retires. If issue & id_wreg & id_dest≠0, e[1] ← new entry; otherwise e[1] ← invalid (bubble).
- Matching per operand i (combinational): consider only valid entries with dest == src_i, src_i ≠ 0 and id_use[i]=1. The youngest match (smallest s) wins.
  - No match: fwd_i = 0.
  - Match, ready: fwd_i = s.
  - Match, not ready: data hazard. An older ready match is not used.
- MDU counter mc: issue of an MDU op loads MDU_II-1. Otherwise mc decrements when nonzero. mdu_busy = (mc≠0).
- stall = id_valid & (any operand data hazard | (id_class==10 & mdu_busy)).
- id_valid=0 forces stall=0, fwd=0, and a bubble into stage 1.
- fwd is computed even while stalling. The consumer ignores it until issue.
- stall_count increments on every stall cycle and saturates at 0xFFFFFFFF.
- An instruction with id_wreg=0 (sw, beq, j) still checks its sources but creates no entry.

## Timing
- stall, wpcir, issue, fwd, mdu_busy are combinational from state and ID inputs. There is no added latency.
- State updates on the rising clk edge. A stalled instruction is re-evaluated next cycle against the advanced scoreboard.
- Load-use with LOAD_LAT=1: consumer directly behind the load stalls 1 cycle, then fwd = 2. Load two instructions ahead: fwd = 2, no stall.
- Stage DEPTH forwarding covers the register-file write in that same cycle. After retirement, fwd = 0.
- MDU back-to-back: the second MDU op stalls MDU_II-1 cycles.
- Reset (asserted at any time, including mid-stall): all entries invalid, mc = 0, stall_count = 0. Outputs then read stall=0, wpcir=1, fwd=0, mdu_busy=0, issue=id_valid. Release is synchronous to the next edge.

## Test plan
- Reset mid-operation: fill the scoreboard, assert rst between edges → entries clear immediately, stall=0, fwd=0, stall_count=0.
- ALU chain add $3←$1,$2; sub $4←$3,$3 back-to-back → no stall, fwd=1 for both operands. A third instruction using $3 → fwd=2. A fourth → fwd=3. A fifth → fwd=0.
- lw $5; add $6←$5,$0 (defaults) → stall=1, wpcir=0 for exactly 1 cycle, fwd_0=2 on the issue cycle, stall_count=1. With LOAD_LAT=2 and DEPTH=4 → 2 stall cycles, fwd=3.
- Youngest-wins: add $7; lw $7; or $8←$7 → lw is youngest and not ready → stall 1 cycle, then fwd=2 (the load, not the add).
- $0 and unused operands: lw $0 followed by a consumer of $0 → no stall, fwd=0. lw $9 followed by j with id_use=00 → no stall.
- MDU: two MDU ops back-to-back with MDU_II=4 → second op stalls 3 cycles. mdu_busy is high for 3 cycles after the first issue. A consumer of the first MDU result at stage 3 → fwd=3.
